// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes, FSM state encodings and decode helper
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_WAIT_DATA = 2'd1,
        W_WAIT_ADDR = 2'd2,
        W_RESP      = 2'd3
    } axi_wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } axi_rstate_e;

    // True when a byte address falls inside a window of span_bytes starting at 0.
    // The extra top bit keeps a full 4 GiB span representable.
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [32:0] span_bytes);
        return ({1'b0, addr} < span_bytes);
    endfunction

endpackage

// File: rtl/axi_lite_word_mem.sv
// rtl/axi_lite_word_mem.sv - word-addressed memory with byte-strobed write and synchronous clear
module axi_lite_word_mem #(
    parameter int data_width = 32,
    parameter int DEPTH      = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we_i,
    input  logic [$clog2(DEPTH)-1:0]      waddr_i,
    input  logic [data_width-1:0]         wdata_i,
    input  logic [data_width/8-1:0]       wstrb_i,
    input  logic [$clog2(DEPTH)-1:0]      raddr_i,
    output logic [data_width-1:0]         rdata_o
);

    localparam int STRB_W = data_width / 8;

    logic [data_width-1:0] mem_q [DEPTH];

    // Whole array cleared while reset is held; otherwise only enabled byte lanes change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous read: the caller registers it, so a same-edge write is not yet visible.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// rtl/axi4_lite_slave_mem.sv - AXI4-Lite responder with independent read/write FSMs over word memory
module axi4_lite_slave_mem
    import axi4_lite_pkg::*;
#(
    parameter int data_width = 32,
    parameter int DEPTH      = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     AWvalid,
    input  logic [31:0]              AWaddr,
    output logic                     AWready,
    input  logic                     Wvalid,
    input  logic [data_width-1:0]    Wdata,
    input  logic [data_width/8-1:0]  Wstrb,
    output logic                     Wready,
    output logic                     Bvalid,
    output logic [1:0]               Bresp,
    input  logic                     Bready,
    input  logic                     ARvalid,
    input  logic [31:0]              ARaddr,
    output logic                     ARready,
    output logic                     Rvalid,
    output logic [data_width-1:0]    Rdata,
    output logic [1:0]               Rresp,
    input  logic                     Rready
);

    localparam int          STRB_W = data_width / 8;
    localparam int          LSB    = $clog2(STRB_W);
    localparam int          IDX_W  = $clog2(DEPTH);
    localparam logic [32:0] SPAN   = 33'(DEPTH * STRB_W);

    // Write channel state
    axi_wstate_e             w_state_q;
    logic                    awready_q;
    logic                    wready_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic [31:0]             waddr_q;
    logic [data_width-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;

    // Read channel state
    axi_rstate_e             r_state_q;
    logic                    arready_q;
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic [data_width-1:0]   rdata_q;

    // Handshakes use the registered ready flags, so they are glitch-free within a cycle
    logic aw_hs;
    logic w_hs;
    logic ar_hs;

    assign aw_hs = AWvalid & awready_q;
    assign w_hs  = Wvalid  & wready_q;
    assign ar_hs = ARvalid & arready_q;

    // Commit path: the address/data pair that completes this cycle, wherever each half came from
    logic                    commit;
    logic [31:0]             commit_addr;
    logic [data_width-1:0]   commit_data;
    logic [STRB_W-1:0]       commit_strb;
    logic                    commit_ok;
    logic [1:0]              bresp_d;

    // Select the halves of the write that complete this cycle
    always_comb begin
        commit      = 1'b0;
        commit_addr = AWaddr;
        commit_data = Wdata;
        commit_strb = Wstrb;
        case (w_state_q)
            W_IDLE: begin
                commit = aw_hs & w_hs;
            end
            W_WAIT_DATA: begin
                commit      = w_hs;
                commit_addr = waddr_q;
            end
            W_WAIT_ADDR: begin
                commit      = aw_hs;
                commit_data = wdata_q;
                commit_strb = wstrb_q;
            end
            default: begin
                commit = 1'b0;
            end
        endcase
    end

    assign commit_ok = addr_in_range(commit_addr, SPAN);
    assign bresp_d   = commit_ok ? RESP_OKAY : RESP_SLVERR;

    // Read decode
    logic                    rd_ok;
    logic [data_width-1:0]   mem_rdata;
    logic [data_width-1:0]   rdata_d;
    logic [1:0]              rresp_d;

    assign rd_ok   = addr_in_range(ARaddr, SPAN);
    assign rdata_d = rd_ok ? mem_rdata : '0;
    assign rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;

    axi_lite_word_mem #(
        .data_width (data_width),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (commit & commit_ok),
        .waddr_i (commit_addr[LSB +: IDX_W]),
        .wdata_i (commit_data),
        .wstrb_i (commit_strb),
        .raddr_i (ARaddr[LSB +: IDX_W]),
        .rdata_o (mem_rdata)
    );

    // Write FSM: join AW and W in either order, commit once, hold B until accepted
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= bresp_d;
                        w_state_q <= W_RESP;
                    end else if (aw_hs) begin
                        waddr_q   <= AWaddr;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_WAIT_DATA;
                    end else if (w_hs) begin
                        wdata_q   <= Wdata;
                        wstrb_q   <= Wstrb;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b0;
                        w_state_q <= W_WAIT_ADDR;
                    end else begin
                        // Also the path that raises ready on the first cycle out of reset
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_WAIT_DATA: begin
                    if (w_hs) begin
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= bresp_d;
                        w_state_q <= W_RESP;
                    end
                end
                W_WAIT_ADDR: begin
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= bresp_d;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (Bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: capture data on AR handshake, hold R until accepted
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rdata_d;
                        rresp_q   <= rresp_d;
                        r_state_q <= R_RESP;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (Rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign AWready = awready_q;
    assign Wready  = wready_q;
    assign Bvalid  = bvalid_q;
    assign Bresp   = bresp_q;
    assign ARready = arready_q;
    assign Rvalid  = rvalid_q;
    assign Rdata   = rdata_q;
    assign Rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// tb/tb_axi4_lite_slave_mem.sv - self-checking bench for axi4_lite_slave_mem
module tb_axi4_lite_slave_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
    logic        ARvalid, ARready, Rvalid, Rready;
    logic [31:0] AWaddr, Wdata, ARaddr, Rdata;
    logic [3:0]  Wstrb;
    logic [1:0]  Bresp, Rresp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi4_lite_slave_mem #(.data_width(32), .DEPTH(64)) dut (
        .clk(clk), .reset(reset),
        .AWvalid(AWvalid), .AWaddr(AWaddr), .AWready(AWready),
        .Wvalid(Wvalid), .Wdata(Wdata), .Wstrb(Wstrb), .Wready(Wready),
        .Bvalid(Bvalid), .Bresp(Bresp), .Bready(Bready),
        .ARvalid(ARvalid), .ARaddr(ARaddr), .ARready(ARready),
        .Rvalid(Rvalid), .Rdata(Rdata), .Rresp(Rresp), .Rready(Rready)
    );

    // Reference model: 64 words of 4 bytes, 256-byte window
    logic [31:0] model_mem [64];

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [5:0] idx;
        if (a >= 32'd256) return 2'b10;
        idx = 6'(a / 32'd4);
        for (int b = 0; b < 4; b++)
            if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic void model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        if (a >= 32'd256) begin
            d = 32'd0;
            r = 2'b10;
        end else begin
            d = model_mem[6'(a / 32'd4)];
            r = 2'b00;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int bp, output logic [1:0] resp);
        bit   aw_done = 0, w_done = 0, early = 0;
        int   cyc = 0;
        logic hs_aw, hs_w;
        Bready = (bp == 0);
        while (!(aw_done && w_done) && cyc < 40) begin
            AWaddr  = a;
            Wdata   = d;
            Wstrb   = s;
            AWvalid = !aw_done && cyc >= aw_dly;
            Wvalid  = !w_done && cyc >= w_dly;
            if (Bvalid) early = 1;
            hs_aw = AWvalid && AWready;
            hs_w  = Wvalid && Wready;
            @(posedge clk); #1;
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            cyc++;
        end
        AWvalid = 0;
        Wvalid  = 0;
        check("wr_handshake_done", 32'(aw_done && w_done), 32'd1);
        check("wr_no_early_bvalid", 32'(early), 32'd0);
        check("wr_bvalid_latency", 32'(Bvalid), 32'd1);
        resp = Bresp;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("wr_bp_hold", 32'({Bvalid, Bresp, AWready, Wready}), 32'({1'b1, resp, 2'b00}));
        end
        Bready = 1;
        @(posedge clk); #1;
        check("wr_b_release", 32'({Bvalid, AWready, Wready}), 32'b011);
    endtask

    task automatic axi_read(input logic [31:0] a, input int bp, output logic [31:0] d, output logic [1:0] resp);
        bit   done = 0;
        int   cyc = 0;
        logic hs;
        Rready  = (bp == 0);
        ARaddr  = a;
        ARvalid = 1;
        while (!done && cyc < 20) begin
            hs = ARready;
            @(posedge clk); #1;
            done = hs;
            cyc++;
        end
        ARvalid = 0;
        check("rd_handshake_done", 32'(done), 32'd1);
        check("rd_rvalid_latency", 32'(Rvalid), 32'd1);
        d    = Rdata;
        resp = Rresp;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("rd_bp_hold_ctl", 32'({Rvalid, Rresp, ARready}), 32'({1'b1, resp, 1'b0}));
            check("rd_bp_hold_data", Rdata, d);
        end
        Rready = 1;
        @(posedge clk); #1;
        check("rd_r_release", 32'({Rvalid, ARready}), 32'b01);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          bp;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vt [19];

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        logic [31:0] d, ed, a, old;
        logic [1:0]  r, er;

        vt[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0,        2'b00};
        vt[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 0, 0, 0, 32'hDEADBEEF, 2'b00};
        vt[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 0, 0, 0, 32'h0,        2'b00};
        vt[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 0, 0, 0, 32'h0,        2'b00};
        vt[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 0, 0, 0, 32'h11BB33DD, 2'b00};
        vt[5]  = '{1'b1, 32'h30,       32'hCAFEF00D, 4'hF, 0, 3, 0, 32'h0,        2'b00};
        vt[6]  = '{1'b0, 32'h30,       32'h0,        4'h0, 0, 0, 0, 32'hCAFEF00D, 2'b00};
        vt[7]  = '{1'b1, 32'h34,       32'h12345678, 4'hF, 3, 0, 0, 32'h0,        2'b00};
        vt[8]  = '{1'b0, 32'h34,       32'h0,        4'h0, 0, 0, 0, 32'h12345678, 2'b00};
        vt[9]  = '{1'b1, 32'h100,      32'hFFFFFFFF, 4'hF, 0, 0, 5, 32'h0,        2'b10};
        vt[10] = '{1'b0, 32'h100,      32'h0,        4'h0, 0, 0, 5, 32'h0,        2'b10};
        vt[11] = '{1'b0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00};
        vt[12] = '{1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 0, 0, 0, 32'h0,        2'b00};
        vt[13] = '{1'b0, 32'h23,       32'h0,        4'h0, 0, 0, 0, 32'h11BB33DD, 2'b00};
        vt[14] = '{1'b1, 32'hFC,       32'h0BADCAFE, 4'hF, 0, 0, 5, 32'h0,        2'b00};
        vt[15] = '{1'b0, 32'hFE,       32'h0,        4'h0, 0, 0, 5, 32'h0BADCAFE, 2'b00};
        vt[16] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b10};
        vt[17] = '{1'b1, 32'h44,       32'h55667788, 4'h8, 2, 2, 0, 32'h0,        2'b00};
        vt[18] = '{1'b0, 32'h44,       32'h0,        4'h0, 0, 0, 0, 32'h55000000, 2'b00};

        for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;

        reset = 0;
        AWvalid = 0; AWaddr = 0; Wvalid = 0; Wdata = 0; Wstrb = 0; Bready = 1;
        ARvalid = 0; ARaddr = 0; Rready = 1;

        // Reset values, then ready on the first cycle after release
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 32'({AWready, Wready, ARready, Bvalid, Rvalid, Bresp, Rresp}), 32'd0);
        check("rst_rdata", Rdata, 32'd0);
        reset = 1;
        @(posedge clk); #1;
        check("rst_release_ready", 32'({AWready, Wready, ARready}), 32'b111);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            if (vt[i].wr) begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].aw_dly, vt[i].w_dly, vt[i].bp, r);
                void'(model_write(vt[i].addr, vt[i].data, vt[i].strb));
                check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vt[i].exp_resp));
            end else begin
                axi_read(vt[i].addr, vt[i].bp, d, r);
                check($sformatf("vec%0d_rdata", i), d, vt[i].exp_data);
                check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vt[i].exp_resp));
            end
        end

        // Same-cycle read and write to one word: read sees the old value
        axi_write(32'h50, 32'h01010101, 4'hF, 0, 0, 0, r);
        void'(model_write(32'h50, 32'h01010101, 4'hF));
        AWaddr = 32'h50; Wdata = 32'h02020202; Wstrb = 4'hF; ARaddr = 32'h50;
        AWvalid = 1; Wvalid = 1; ARvalid = 1;
        check("conc_ready", 32'({AWready, Wready, ARready}), 32'b111);
        @(posedge clk); #1;
        AWvalid = 0; Wvalid = 0; ARvalid = 0;
        check("conc_valids", 32'({Bvalid, Rvalid, Bresp, Rresp}), 32'b1100_00);
        check("conc_old_data", Rdata, 32'h01010101);
        void'(model_write(32'h50, 32'h02020202, 4'hF));
        @(posedge clk); #1;
        check("conc_release", 32'({Bvalid, Rvalid, AWready, Wready, ARready}), 32'b00111);
        axi_read(32'h50, 0, d, r);
        check("conc_new_data", d, 32'h02020202);

        // Reset while write waits for data and read response is held
        axi_write(32'h60, 32'h600DF00D, 4'hF, 0, 0, 0, r);
        void'(model_write(32'h60, 32'h600DF00D, 4'hF));
        AWaddr = 32'h60; ARaddr = 32'h60; AWvalid = 1; ARvalid = 1; Rready = 0;
        @(posedge clk); #1;
        AWvalid = 0; ARvalid = 0;
        check("mid_state", 32'({AWready, Wready, Rvalid}), 32'b011);
        reset = 0;
        @(posedge clk); #1;
        check("mid_rst_ctl", 32'({AWready, Wready, ARready, Bvalid, Rvalid, Bresp, Rresp}), 32'd0);
        check("mid_rst_rdata", Rdata, 32'd0);
        reset = 1; Rready = 1;
        for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mid_no_resp", 32'({Bvalid, Rvalid}), 32'd0);
        end
        check("mid_ready", 32'({AWready, Wready, ARready}), 32'b111);
        axi_read(32'h60, 0, d, r);
        check("mid_cleared", d, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) a = 32'h100 + $urandom_range(0, 4095);
            else a = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2), r);
                er = model_write(a, d, Wstrb);
                check("rand_bresp", 32'(r), 32'(er));
            end else begin
                axi_read(a, $urandom_range(0, 2), d, r);
                model_read(a, ed, er);
                check("rand_rdata", d, ed);
                check("rand_rresp", 32'(r), 32'(er));
            end
        end

        // Full readback
        for (int i = 0; i < 64; i++) begin
            a = 32'(i * 4);
            old = 32'd0;
            axi_read(a, 0, d, r);
            model_read(a, old, er);
            check($sformatf("final_word%0d", i), d, old);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_mem.md
# axi4_lite_slave_mem

AXI4-Lite slave (responder) backed by a word-addressed on-chip memory. It is the far end of the core-side AXI4-Lite master: it accepts instruction fetches, data loads and data stores issued by that master and returns OKAY/SLVERR responses. Read and write channels run independent FSMs, so a read and a write may be in flight at the same time.

## Interface
- data_width, 32, data bus width; must be 32 or 64
- DEPTH, 64, number of memory words; must be a power of 2 and ≥ 2
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low
- AWvalid  in  1  write address valid
- AWaddr  in  32  write byte address
- AWready  out  1  write address accepted
- Wvalid  in  1  write data valid
- Wdata  in  data_width  write data
- Wstrb  in  data_width/8  byte-lane enables
- Wready  out  1  write data accepted
- Bvalid  out  1  write response valid
- Bresp  out  2  00 OKAY, 10 SLVERR
- Bready  in  1  master accepts response
- ARvalid  in  1  read address valid
- ARaddr  in  32  read byte address
- ARready  out  1  read address accepted
- Rvalid  out  1  read data valid
- Rdata  out  data_width  read data
- Rresp  out  2  00 OKAY, 10 SLVERR
- Rready  in  1  master accepts read data

## Operation
- Address decode: LSB = log2(data_width/8); word index = addr[LSB +: log2(DEPTH)]; low LSB bits ignored (no misalignment error). Address in range iff addr < DEPTH·data_width/8; otherwise SLVERR.
- Write FSM states: W_IDLE, W_WAIT_DATA (address latched), W_WAIT_ADDR (data+strobe latched), W_RESP.
  - W_IDLE: AWready=Wready=1. AW and W handshake in same cycle → commit, go W_RESP. AW only → latch address, W_WAIT_DATA. W only → latch data/strobe, W_WAIT_ADDR.
  - W_WAIT_DATA: AWready=0, Wready=1; W handshake → commit, W_RESP. W_WAIT_ADDR symmetric.
  - Commit: in-range → each byte lane with Wstrb[i]=1 updated, others unchanged, Bresp=00; out-of-range → memory untouched, Bresp=10. Wstrb=0 in range → no change, OKAY.
  - W_RESP: Bvalid=1, Bresp stable until Bvalid&Bready, then W_IDLE. No AW/W accepted in W_RESP.
- Read FSM states: R_IDLE (ARready=1), R_RESP (ARready=0, Rvalid=1).
  - AR handshake → Rdata = memory word (in range, Rresp=00) or 0 (out of range, Rresp=10); R_RESP.
  - Rdata/Rresp held stable until Rvalid&Rready, then R_IDLE.
- Same-cycle read handshake and write commit to same word: read returns pre-write value.
- Memory cleared to 0 during reset.

## Timing
- All outputs registered. Reset values: AWready=Wready=ARready=0, Bvalid=Rvalid=0, Bresp=Rresp=00, Rdata=0.
- First cycle after reset released: AWready=Wready=ARready=1.
- Write latency: final AW/W handshake at edge n → Bvalid=1 in cycle n+1; with Bready held high, Bvalid drops and AWready/Wready return to 1 in cycle n+2.
- Read latency: AR handshake at edge n → Rvalid=1 with data in cycle n+1; with Rready high, ARready returns to 1 in cycle n+2. Sustained throughput one read per 2 cycles.
- Back-pressure: Bready/Rready low holds response indefinitely; outputs never change while valid and not accepted.
- Reset asserted mid-transaction: both FSMs to idle next edge, latched address/data discarded, no response issued, memory cleared.

## Structure
- Shared package axi4_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write/read FSM state encodings; reused by the master.
- One sub-module, axi_lite_word_mem: DEPTH×data_width array, byte-strobed synchronous write port, read port, synchronous clear. FSMs and decode stay in top.

## Test plan
- AW and W same cycle, AWaddr=0x10, Wdata=0xDEADBEEF, Wstrb=4'hF, Bready=1 → Bvalid next cycle, Bresp=00; read 0x10 → Rdata=0xDEADBEEF, Rresp=00, Rvalid one cycle after AR handshake.
- AW at cycle 0, W at cycle 3 (and reverse order) → single commit at W/AW handshake, one Bvalid pulse, memory correct.
- Word 0x20 = 0x11223344, write Wdata=0xAABBCCDD, Wstrb=4'b0101 → read returns 0x11BB33DD.
- Write/read AWaddr=ARaddr=0x100 (DEPTH=64) → Bresp=10, Rresp=10, Rdata=0, memory unchanged.
- Bready/Rready held low 5 cycles → Bvalid/Rvalid, Bresp/Rresp, Rdata stable; AWready/ARready stay 0 until accepted.
- Reset pulsed while in W_WAIT_DATA and R_RESP → all outputs reset values, no B/R response, readback of previously written word = 0.
